// File: rtl/s_div32_if.sv
// Start/done handshake bus for the s_div32 sequential signed divider.
interface s_div32_if;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;
  logic        done;
  logic        busy;

  modport master (
    output start, src1, src2,
    input  quotient, remainder, div_zero, done, busy
  );

  modport slave (
    input  start, src1, src2,
    output quotient, remainder, div_zero, done, busy
  );
endinterface

// File: rtl/s_div32.sv
// Sequential 32-bit signed divider: restoring division on magnitudes, sign fix-up,
// fixed 33-cycle latency (32 iterations + 1 fix cycle), with a cla_32 subtractor.

// 32-bit adder/subtractor: 4-bit carry-lookahead groups with rippled group carry.
module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub_flag,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [31:0] bx;
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  always_comb begin
    bx   = b ^ {32{sub_flag}};
    g    = a & bx;
    p    = a ^ bx;
    c    = '0;
    c[0] = sub_flag;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
    sum   = p ^ c[31:0];
    c_out = c[32];
  end
endmodule

module s_div32 (
  input  logic       clk,
  input  logic       n_rst,
  s_div32_if.slave   bus
);
  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned LAST = 31;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sa_q, sa_d, sb_q, sb_d, zflag_q, zflag_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;
  logic           div_zero_q, div_zero_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic [W:0]     rem_sh;
  logic [W-1:0]   diff;
  logic           c_out;
  logic           trial_neg;

  // Shifted partial remainder minus divisor; bit 32 comes from the borrow out of cla_32.
  assign rem_sh    = {rem_q, dvd_q[W-1]};
  assign trial_neg = rem_sh[W] ^ ~c_out;

  cla_32 u_sub (
    .a        (rem_sh[W-1:0]),
    .b        (dvs_q),
    .sub_flag (1'b1),
    .sum      (diff),
    .c_out    (c_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    zflag_d     = zflag_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.src1[W-1];
          sb_d    = bus.src2[W-1];
          dvd_d   = bus.src1[W-1] ? -bus.src1 : bus.src1;
          dvs_d   = bus.src2[W-1] ? -bus.src2 : bus.src2;
          zflag_d = (bus.src2 == '0);
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // Restoring step: the quotient bit shifts into the vacated dividend LSB.
        rem_d = trial_neg ? rem_sh[W-1:0] : diff;
        dvd_d = {dvd_q[W-2:0], ~trial_neg};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) state_d = FIX;
      end
      FIX: begin
        // With a zero divisor rem holds |src1|, so the signed fix-up restores src1.
        quotient_d  = zflag_q ? '1 : ((sa_q ^ sb_q) ? -dvd_q : dvd_q);
        remainder_d = sa_q ? -rem_q : rem_q;
        div_zero_d  = zflag_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      zflag_q     <= 1'b0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      zflag_q     <= zflag_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_s_div32.sv
// Self-checking bench for s_div32: transaction-level reference model with per-cycle
// comparison, plus hand-computed expectations for the directed cases.
module tb_s_div32;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  s_div32_if bus ();

  s_div32 dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tmo_cnt  = 0;
  int tmo_seen = 0;

  // Hand-computed expectations, indexed by completion number (written by stimulus only).
  logic [31:0] lit_q   [128];
  logic [31:0] lit_r   [128];
  logic        lit_dz  [128];
  logic        lit_use [128];
  int          n_slot = 0;
  int          done_idx = 0;

  // Reference: divide magnitudes with wide arithmetic, then apply the sign rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint ma, mb, qm, rm;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dz = 1'b1;
    end else begin
      ma = longint'(a[31] ? 32'(-a) : a);
      mb = longint'(b[31] ? 32'(-b) : b);
      qm = ma / mb;
      rm = ma % mb;
      q  = (a[31] ^ b[31]) ? 32'(-qm) : 32'(qm);
      r  = a[31] ? 32'(-rm) : 32'(rm);
      dz = 1'b0;
    end
  endfunction

  // Timing model: an accepted request completes exactly 33 edges later.
  int          m_cnt;
  logic [31:0] m_q, m_r, p_q, p_r;
  logic        m_dz, p_dz, m_done, m_busy;

  always @(posedge clk or negedge n_rst) begin : model
    logic [31:0] tq, tr;
    logic        tdz;
    if (!n_rst) begin
      m_cnt <= 0; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_done <= 1'b0; m_busy <= 1'b0;
      p_q <= '0; p_r <= '0; p_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          ref_div(bus.src1, bus.src2, tq, tr, tdz);
          p_q <= tq; p_r <= tr; p_dz <= tdz;
          m_cnt <= 33;
          m_busy <= 1'b1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    check("done",      32'(bus.done),     32'(m_done));
    check("busy",      32'(bus.busy),     32'(m_busy));
    check("quotient",  bus.quotient,      m_q);
    check("remainder", bus.remainder,     m_r);
    check("div_zero",  32'(bus.div_zero), 32'(m_dz));
    if (!n_rst) begin
      check("rst_quotient",  bus.quotient,      32'd0);
      check("rst_remainder", bus.remainder,     32'd0);
      check("rst_div_zero",  32'(bus.div_zero), 32'd0);
      check("rst_done",      32'(bus.done),     32'd0);
      check("rst_busy",      32'(bus.busy),     32'd0);
    end
    if (m_done) begin
      if (lit_use[done_idx]) begin
        check("lit_quotient",  bus.quotient,      lit_q[done_idx]);
        check("lit_remainder", bus.remainder,     lit_r[done_idx]);
        check("lit_div_zero",  32'(bus.div_zero), 32'(lit_dz[done_idx]));
      end
      done_idx <= done_idx + 1;
    end
    check("done_timeout", 32'(tmo_cnt), 32'(tmo_seen));
    tmo_seen <= tmo_cnt;
  end

  // Drives a request at the current negedge; start drops after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit use_lit,
                       input logic [31:0] q, input logic [31:0] r, input logic dz,
                       input bit completes);
    bus.start = 1'b1;
    bus.src1  = a;
    bus.src2  = b;
    if (completes) begin
      lit_use[n_slot] = use_lit;
      lit_q[n_slot]   = q;
      lit_r[n_slot]   = r;
      lit_dz[n_slot]  = dz;
      n_slot++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.src1  = $urandom;
    bus.src2  = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) tmo_cnt++;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic dz);
    issue(a, b, 1'b1, q, r, dz, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [31:0] ra, rb;
    for (int i = 0; i < 128; i++) lit_use[i] = 1'b0;
    bus.start = 1'b0;
    bus.src1  = '0;
    bus.src2  = '0;
    n_rst     = 1'b1;
    #2 n_rst  = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    run(-32'd100, 32'd7,  32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run(32'd100,  -32'd7, 32'hFFFF_FFF2, 32'd2,         1'b0);
    run(-32'd100, -32'd7, 32'd14,        32'hFFFF_FFFE, 1'b0);
    run(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run(32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0, 1'b0);
    run(32'd5,         32'h8000_0000, 32'd0,         32'd5, 1'b0);

    // A start pulse mid-operation must be ignored.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    bus.start = 1'b1; bus.src1 = 32'd1; bus.src2 = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Back-to-back: second request raised in the done cycle.
    run(32'd1000, -32'd3, 32'hFFFF_FEB3, 32'd1, 1'b0);
    run(-32'd77, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFE, 1'b0);

    // Reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Randomized operands, gaps and ignored mid-operation start pulses.
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       rb = 32'h8000_0000;
        4:       rb = 32'hFFFF_FFFF;
        5:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb, 1'b0, '0, '0, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        bus.start = 1'b1; bus.src1 = $urandom; bus.src2 = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
